cpu_csr_unit: RTL



---
 rtl/cpu_csr_unit_pkg.sv | 50 +++++
 rtl/cpu_csr_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cpu_csr_unit_pkg.sv
// rtl/cpu_csr_unit_pkg.sv - shared CSR addresses, request/op/state encodings and decode helpers
package cpu_csr_unit_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCYCLE = 12'hB00;

  localparam logic [1:0] KIND_CSR   = 2'd0;
  localparam logic [1:0] KIND_ECALL = 2'd1;
  localparam logic [1:0] KIND_MRET  = 2'd2;
  localparam logic [1:0] KIND_RSVD  = 2'd3;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  op;
    logic [11:0] csr;
    logic [31:0] src;
    logic        src_zero;
    logic [31:0] pc;
  } csr_req_t;

  function automatic logic csr_supported(input logic [11:0] addr);
    return (addr == CSR_MTVEC) || (addr == CSR_MEPC) || (addr == CSR_MCYCLE);
  endfunction

  function automatic logic op_defined(input logic [2:0] op);
    case (op)
      OP_RW, OP_RS, OP_RC, OP_RWI, OP_RSI, OP_RCI: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // Plain writes always commit; set/clear with a zero source are pure reads.
  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_RW) || (op == OP_RWI);
  endfunction

endpackage

// File: rtl/cpu_csr_unit.sv
// rtl/cpu_csr_unit.sv - Zicsr / ECALL / MRET read-modify-write sequencer driving the CSR file
module cpu_csr_unit
  import cpu_csr_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_src,
  input  logic        req_src_zero,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        csr_wenable
);

  logic [1:0]  state;
  csr_req_t    req_q;
  logic [31:0] old_q;
  logic        illegal;
  logic        needs_write;
  logic        is_trap;
  logic [31:0] alu_wdata;

  // Legality and write decisions depend only on latched request fields.
  always_comb begin
    illegal = (req_q.kind == KIND_RSVD) ||
              ((req_q.kind == KIND_CSR) &&
               (!csr_supported(req_q.csr) || !op_defined(req_q.op)));
    needs_write = (req_q.kind == KIND_ECALL) ||
                  ((req_q.kind == KIND_CSR) && !illegal &&
                   (op_is_write(req_q.op) || !req_q.src_zero));
    is_trap = (req_q.kind == KIND_ECALL) || (req_q.kind == KIND_MRET);
  end

  always_comb begin
    alu_wdata = req_q.src;
    case (req_q.op)
      OP_RW, OP_RWI: alu_wdata = req_q.src;
      OP_RS, OP_RSI: alu_wdata = old_q | req_q.src;
      OP_RC, OP_RCI: alu_wdata = old_q & ~req_q.src;
      default:       alu_wdata = req_q.src;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      req_q <= '0;
      old_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q <= '{kind: req_kind, op: req_op, csr: req_csr, src: req_src,
                       src_zero: req_src_zero, pc: req_pc};
            state <= ST_READ;
          end
        end
        ST_READ: begin
          old_q <= csr_rdata;
          state <= needs_write ? ST_WRITE : ST_DONE;
        end
        ST_WRITE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready      = (state == ST_IDLE);
    csr_raddr      = 12'h000;
    csr_waddr      = 12'h000;
    csr_wdata      = 32'h0;
    csr_wenable    = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 32'h0;
    resp_illegal   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state)
      ST_READ: begin
        case (req_q.kind)
          KIND_ECALL: csr_raddr = CSR_MTVEC;
          KIND_MRET:  csr_raddr = CSR_MEPC;
          default:    csr_raddr = req_q.csr;
        endcase
      end
      ST_WRITE: begin
        csr_wenable = 1'b1;
        if (req_q.kind == KIND_ECALL) begin
          csr_waddr = CSR_MEPC;
          csr_wdata = req_q.pc;
        end else begin
          csr_waddr = req_q.csr;
          csr_wdata = alu_wdata;
        end
      end
      ST_DONE: begin
        resp_valid     = 1'b1;
        resp_illegal   = illegal;
        resp_rdata     = (req_q.kind == KIND_CSR && !illegal) ? old_q : 32'h0;
        redirect_valid = is_trap;
        if (req_q.kind == KIND_ECALL)
          redirect_pc = old_q & ~32'h3;
        else if (req_q.kind == KIND_MRET)
          redirect_pc = old_q;
      end
      default: ;
    endcase
  end

endmodule
